// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and arbiter FSM state shared by alu and alu_arbiter.
// Exports ALU_* opcodes (4-bit) and arb_state_t {IDLE, EXEC, RESP}.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_BEQ = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational integer ALU; unknown opcodes give zero.
// Ports: op (operation), a/b (operands), y (result, wraps modulo 2^DATA_WIDTH).
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic [DATA_WIDTH-1:0]    y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_XOR: y = a ^ b;
      ALU_BEQ: y = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one alu between two valid/ready requesters.
// Ports: clk, reset (async high), req_* handshake in, rsp_* handshake out, busy.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0][OPCODE_LENGTH-1:0] req_op,
  input  logic [1:0][DATA_WIDTH-1:0]    req_a,
  input  logic [1:0][DATA_WIDTH-1:0]    req_b,
  output logic [1:0]                    rsp_valid,
  input  logic [1:0]                    rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          busy
);

  arb_state_t               state;
  logic                     grant_q;
  logic                     last_grant;
  logic                     win;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    a_q;
  logic [DATA_WIDTH-1:0]    b_q;
  logic [DATA_WIDTH-1:0]    result_q;
  logic [DATA_WIDTH-1:0]    alu_y;

  // Under contention the lane that did not win last time goes next.
  function automatic logic rr_pick(
    input logic [1:0] v,
    input logic       last
  );
    logic g;
    unique case (1'b1)
      (v == 2'b11): g = ~last;
      (v == 2'b10): g = 1'b1;
      default:      g = 1'b0;
    endcase
    return g;
  endfunction

  assign win = rr_pick(req_valid, last_grant);

  // Gated by reset so no grant is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && |req_valid)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP)
      rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_result = result_q;
  assign busy       = (state != IDLE);

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (alu_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_q <= win;
            op_q    <= req_op[win];
            a_q     <= req_a[win];
            b_q     <= req_b[win];
            state   <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_y;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            last_grant <= grant_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a model.
// Drives inputs on the falling edge and samples 1 time unit later.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][OW-1:0]    req_op;
  logic [1:0][DW-1:0]    req_a;
  logic [1:0][DW-1:0]    req_b;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DW-1:0]         rsp_result;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;
  int last_g;
  logic [3:0] ops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hb};

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_WIDTH   (DW),
    .OPCODE_LENGTH(OW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] ref_alu(
    input logic [3:0]    op,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    longint unsigned ua, ub, m;
    ua = 64'(a);
    ub = 64'(b);
    m  = 64'd1 << DW;
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return DW'((ua + ub) % m);
      4'h3: return DW'((ua + m - ub) % m);
      4'h4: return a ^ b;
      4'h8: return (a == b) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  function automatic int pick(input logic [1:0] v, input int last);
    if (v[0] && v[1]) return 1 - last;
    return v[0] ? 0 : 1;
  endfunction

  task automatic chk(
    input string         tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from an IDLE falling edge back to the next IDLE
  // falling edge. hold = stall cycles in RESP (other lane's rsp_ready high
  // meanwhile); keep = winner keeps valid; late = lanes raising valid in EXEC.
  task automatic run_txn(
    input int         hold,
    input bit         keep,
    input logic [1:0] late
  );
    int            g;
    logic [1:0]    gm;
    logic [DW-1:0] exp;
    g   = pick(req_valid, last_g);
    gm  = 2'b01 << g;
    exp = ref_alu(req_op[g], req_a[g], req_b[g]);
    rsp_ready = (hold > 0) ? 2'b00 : 2'b11;
    #1;
    chk("req_ready_idle", DW'(req_ready), DW'(gm));
    chk("busy_idle", DW'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid[g] = 1'b0;
    req_valid = req_valid | late;
    #1;
    chk("busy_exec", DW'(busy), 1);
    chk("rsp_valid_exec", DW'(rsp_valid), 0);
    chk("req_ready_exec", DW'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = (hold > 0) ? ~gm : 2'b11;
    #1;
    chk("rsp_valid_resp", DW'(rsp_valid), DW'(gm));
    chk("rsp_result", rsp_result, exp);
    chk("busy_resp", DW'(busy), 1);
    chk("req_ready_resp", DW'(req_ready), 0);
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == hold) rsp_ready = 2'b11;
      #1;
      chk("rsp_valid_hold", DW'(rsp_valid), DW'(gm));
      chk("rsp_result_hold", rsp_result, exp);
      chk("req_ready_hold", DW'(req_ready), 0);
    end
    @(posedge clk);
    @(negedge clk);
    last_g = g;
  endtask

  task automatic set_req(
    input int            l,
    input logic [3:0]    op,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    req_op[l] = op;
    req_a[l]  = a;
    req_b[l]  = b;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    last_g    = 1;
    #2;
    chk("rst_req_ready", DW'(req_ready), 0);
    chk("rst_rsp_valid", DW'(rsp_valid), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", DW'(busy), 0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    set_req(0, 4'h2, 5, 7);
    req_valid = 2'b01;
    run_txn(0, 0, 2'b00);

    set_req(0, 4'h3, 10, 3);
    set_req(1, 4'h4, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) run_txn(0, 1, 2'b00);
    req_valid = 2'b00;

    set_req(0, 4'h2, 1, 2);
    set_req(1, 4'h8, 32'hDEADBEEF, 32'hDEADBEEF);
    req_valid = 2'b10;
    run_txn(4, 0, 2'b01);
    chk("after_hold_grant0", DW'(pick(req_valid, last_g)), 0);
    run_txn(0, 0, 2'b00);

    set_req(0, 4'hF, 32'hFFFFFFFF, 1);
    req_valid = 2'b01;
    run_txn(0, 0, 2'b00);
    set_req(0, 4'h2, 32'hFFFFFFFF, 1);
    req_valid = 2'b01;
    run_txn(0, 0, 2'b00);

    set_req(1, 4'h0, 32'hF0F0, 32'hFF00);
    req_valid = 2'b10;
    run_txn(2, 0, 2'b00);

    set_req(0, 4'h2, 3, 4);
    req_valid = 2'b01;
    #1;
    chk("pre_rst_ready", DW'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("pre_rst_busy", DW'(busy), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", DW'(busy), 0);
    chk("midrst_rsp_valid", DW'(rsp_valid), 0);
    chk("midrst_req_ready", DW'(req_ready), 0);
    chk("midrst_result", rsp_result, 0);
    @(negedge clk);
    reset  = 1'b0;
    last_g = 1;
    set_req(0, 4'h1, 32'h11, 32'h22);
    set_req(1, 4'h3, 0, 1);
    #1;
    chk("post_rst_grant", DW'(req_ready), 1);
    run_txn(0, 0, 2'b00);
    run_txn(0, 0, 2'b00);

    for (int it = 0; it < 40; it++) begin
      for (int l = 0; l < 2; l++) begin
        if (!req_valid[l] && $urandom_range(0, 1) == 1) begin
          req_valid[l] = 1'b1;
          set_req(l, ops[$urandom_range(0, 6)], $urandom, $urandom);
          if ($urandom_range(0, 3) == 0) req_b[l] = req_a[l];
        end
      end
      if (req_valid == 2'b00) begin
        req_valid[0] = 1'b1;
        set_req(0, ops[$urandom_range(0, 6)], $urandom, $urandom);
      end
      run_txn($urandom_range(0, 2), 0, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters, for example an integer issue path and an address/branch-compare path. Operands are registered, and requesters are granted in round-robin order. Each requester sees a valid/ready request handshake and a valid/ready response handshake. The block sits between the requesters and the ALU datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, width of ALU operation code

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  [1:0]  request i presents an operation
- req_ready  out  [1:0]  request i accepted this cycle (one-hot or zero)
- req_op  in  [1:0][OPCODE_LENGTH-1:0]  operation code per requester
- req_a  in  [1:0][DATA_WIDTH-1:0]  SrcA per requester
- req_b  in  [1:0][DATA_WIDTH-1:0]  SrcB per requester
- rsp_valid  out  [1:0]  result available for requester i (one-hot or zero)
- rsp_ready  in  [1:0]  requester i consumes result
- rsp_result  out  DATA_WIDTH  shared result bus, meaningful only while some rsp_valid bit is high
- busy  out  1  high in EXEC and RESP

## Operation
- FSM states:
  - IDLE: accept one request.
  - EXEC: ALU evaluates registered operands; result captured.
  - RESP: hold result until consumed.
- IDLE: if any req_valid, the winner g is chosen round-robin against last_grant.
  - If only one requester is valid, it wins.
  - If both are valid, the one not equal to last_grant wins.
  - req_ready[g] is driven combinationally high in this cycle; the handshake completes the same cycle.
  - On the handshake, op_q/a_q/b_q/grant_q are loaded and the FSM moves to EXEC.
- EXEC: result_q ← alu(a_q, b_q, op_q) and the FSM moves to RESP, unconditionally.
- RESP: rsp_valid[grant_q]=1 and rsp_result=result_q.
  - When rsp_ready[grant_q] is high, last_grant ← grant_q and the FSM moves to IDLE.
  - Otherwise the FSM holds, with all outputs stable.
- req_ready is 0 outside IDLE. Requests arriving in EXEC/RESP wait; requesters must hold valid and operands stable until ready.
- ALU semantics:
  - AND, OR, ADD (signed), SUB, XOR as usual.
  - BEQ yields 1/0 in bit 0 with upper bits zero.
  - Any other opcode yields 0 and is not flagged as an error.
- Arithmetic wraps modulo 2^DATA_WIDTH; there is no overflow output.
- rsp_ready on a non-granted lane, or in IDLE/EXEC, is ignored.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=0, rsp_valid=0, rsp_result=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
  - All operand/result registers 0.
- Latency: request handshake at edge N, FSM in EXEC during cycle N+1, rsp_valid high during cycle N+2.
- Minimum issue interval is 3 cycles per operation: IDLE, EXEC, RESP with immediate rsp_ready.
- Reset asserted in any state aborts the in-flight operation with no response, forces reset values immediately (asynchronously), and drops the pending grant.
- A requester re-asserting valid in the same cycle its response is consumed is considered in the following IDLE cycle.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0011, ALU_XOR=4'b0100, ALU_BEQ=4'b1000.
  - FSM enum arb_state_t {IDLE, EXEC, RESP}.
- Sub-module: one instance of the existing `alu`, fed from op_q/a_q/b_q. No logic is duplicated.
- Arbiter select is a small combinational function inside this block; no separate arbiter module.

## Test plan
- Req0 only, ADD a=5, b=7, rsp_ready tied 1 → req_ready=2'b01 at cycle 0, rsp_valid=2'b01 at cycle 2, rsp_result=12, busy high in cycles 1–2.
- Both valid every cycle after reset: req0 SUB 10−3, req1 XOR 0xF0^0x0F → grants alternate 0,1,0,1. Results 7 and 0xFF delivered to the matching lanes, each 3 cycles apart.
- Req1 BEQ a=b=0xDEADBEEF, rsp_ready[1] held 0 for 4 cycles → rsp_valid[1] and rsp_result=1 remain stable. req0 requests in the meantime see req_ready=0. Release completes the response, then req0 is granted the next cycle.
- Req0 opcode 4'b1111, a=0xFFFFFFFF, b=1 → rsp_result=0. Also ADD 0xFFFFFFFF+1 → 0 (wrap).
- Reset asserted mid-EXEC (between edges) → rsp_valid, req_ready and busy go 0 immediately. After release, the first request from both lanes is granted to lane 0.
- rsp_ready[0] pulsed while lane 1 holds the response → no state change; lane 1 is still pending.
